// File: rtl/encoder10.sv
// -----------------------------------------------------------------------------
// encoder10 -- two-to-one flit merger for the NoC router datapath.
//
// Merges flit streams In0 and In1 into a single Out stream and reports, on a
// separate S channel, which input every merged flit came from (0 = In0,
// 1 = In1). Arbitration locks onto one input from a packet's head flit to its
// tail flit, so packets are never interleaved. Between packets, a round-robin
// pointer decides ties.
//
// The output is a one-flit slot. Its Out half and its S half are consumed
// independently. A new flit can load into the slot only once both halves have
// retired, or are retiring in the same cycle.
//
// Parameters
//   W         flit width, including the tail marker
//   TAIL_BIT  index of the tail marker (1 = last flit of a packet)
//
// Ports
//   CLK                           rising-edge clock
//   RESET                         asynchronous, active-high reset
//   In0_data/In0_valid/In0_ready  flit input 0
//   In1_data/In1_valid/In1_ready  flit input 1
//   Out_data/Out_valid/Out_ready  merged flit output
//   S_data/S_valid/S_ready        source tag output, one per merged flit
// -----------------------------------------------------------------------------
module encoder10 #(
  parameter int W        = 9,
  parameter int TAIL_BIT = W - 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] In0_data,
  input  logic         In0_valid,
  output logic         In0_ready,
  input  logic [W-1:0] In1_data,
  input  logic         In1_valid,
  output logic         In1_ready,
  output logic [W-1:0] Out_data,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic         S_data,
  output logic         S_valid,
  input  logic         S_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t       state_reg;
  logic         rr_reg;          // input preferred on the next tie in IDLE
  logic [W-1:0] slot_data_reg;
  logic         slot_src_reg;
  logic         out_pend_reg;
  logic         s_pend_reg;

  logic         can_load;
  logic         grant_any;       // some input holds the grant this cycle
  logic         grant_sel;       // index of the granted input
  logic         grant_valid;
  logic [W-1:0] grant_data;
  logic         load;

  // The slot accepts a flit when each half is empty or retiring now. RESET
  // gates this directly, so the readies fall the moment reset asserts rather
  // than waiting for the pends to clear.
  always_comb begin
    can_load = (!out_pend_reg || Out_ready) && (!s_pend_reg || S_ready) && !RESET;
  end

  // Grant selection. Inside a packet, the locked input keeps the grant even
  // while it has no valid flit. A stalled packet therefore holds the lock.
  always_comb begin
    grant_any = 1'b0;
    grant_sel = 1'b0;
    case (state_reg)
      LOCK0: begin
        grant_any = 1'b1;
        grant_sel = 1'b0;
      end
      LOCK1: begin
        grant_any = 1'b1;
        grant_sel = 1'b1;
      end
      default: begin
        if (In0_valid && In1_valid) begin
          grant_any = 1'b1;
          grant_sel = rr_reg;
        end else if (In0_valid) begin
          grant_any = 1'b1;
          grant_sel = 1'b0;
        end else if (In1_valid) begin
          grant_any = 1'b1;
          grant_sel = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    grant_valid = grant_sel ? In1_valid : In0_valid;
    grant_data  = grant_sel ? In1_data  : In0_data;
    In0_ready   = can_load && grant_any && !grant_sel;
    In1_ready   = can_load && grant_any &&  grant_sel;
    load        = can_load && grant_any && grant_valid;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= IDLE;
      rr_reg        <= 1'b0;
      slot_data_reg <= '0;
      slot_src_reg  <= 1'b0;
      out_pend_reg  <= 1'b0;
      s_pend_reg    <= 1'b0;
    end else begin
      // Each half retires on its own handshake. A load in the same cycle
      // overrides these clears below.
      if (Out_ready) begin
        out_pend_reg <= 1'b0;
      end
      if (S_ready) begin
        s_pend_reg <= 1'b0;
      end
      if (load) begin
        slot_data_reg <= grant_data;
        slot_src_reg  <= grant_sel;
        out_pend_reg  <= 1'b1;
        s_pend_reg    <= 1'b1;
        if (grant_data[TAIL_BIT]) begin
          // Packet done: release the lock and favour the other input next.
          state_reg <= IDLE;
          rr_reg    <= !grant_sel;
        end else begin
          state_reg <= grant_sel ? LOCK1 : LOCK0;
        end
      end
    end
  end

  assign Out_data  = slot_data_reg;
  assign Out_valid = out_pend_reg;
  assign S_data    = slot_src_reg;
  assign S_valid   = s_pend_reg;

endmodule

// File: tb/tb_encoder10.sv
// -----------------------------------------------------------------------------
// tb_encoder10 -- self-checking bench for encoder10.
//
// Two source queues drive In0/In1 with a valid that is held until the
// handshake completes. Every cycle, a packet-level reference model (owner of
// the current packet, preferred input, one-flit slot) predicts the outputs
// and the readies. A scoreboard checks that every accepted flit leaves Out and
// S exactly once, in order. The run covers the directed scenarios first and
// then randomised traffic.
// -----------------------------------------------------------------------------
module tb_encoder10;
  localparam int W  = 9;
  localparam int TB = W - 1;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [W-1:0] In0_data, In1_data, Out_data;
  logic         In0_valid, In0_ready, In1_valid, In1_ready;
  logic         Out_valid, Out_ready, S_data, S_valid, S_ready;

  always #5 CLK = ~CLK;

  encoder10 #(.W(W), .TAIL_BIT(TB)) dut (
    .CLK(CLK), .RESET(RESET),
    .In0_data(In0_data), .In0_valid(In0_valid), .In0_ready(In0_ready),
    .In1_data(In1_data), .In1_valid(In1_valid), .In1_ready(In1_ready),
    .Out_data(Out_data), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .S_data(S_data), .S_valid(S_valid), .S_ready(S_ready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Stimulus sources and their willingness (percent per cycle).
  logic [W-1:0] q0[$], q1[$];
  int go0 = 100, go1 = 100, or_pct = 100, sr_pct = 100;
  bit last_t0 = 0, last_t1 = 0;

  // Reference model.
  int           owner = -1;     // input holding the current packet, -1 = none
  int           pref  = 0;      // input preferred on a tie
  bit           m_op = 0, m_sp = 0, m_src = 0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] exp_out[$];
  bit           exp_s[$];

  // Observed output transfers, used by the directed checks.
  logic [W-1:0] o_log[$];
  bit           s_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    if (!(In0_valid && !last_t0)) begin
      if (q0.size() > 0 && $urandom_range(0, 99) < go0) begin
        In0_valid = 1'b1;
        In0_data  = q0[0];
      end else begin
        In0_valid = 1'b0;
        In0_data  = 9'($urandom_range(0, 511));
      end
    end
    if (!(In1_valid && !last_t1)) begin
      if (q1.size() > 0 && $urandom_range(0, 99) < go1) begin
        In1_valid = 1'b1;
        In1_data  = q1[0];
      end else begin
        In1_valid = 1'b0;
        In1_data  = 9'($urandom_range(0, 511));
      end
    end
    Out_ready = ($urandom_range(0, 99) < or_pct);
    S_ready   = ($urandom_range(0, 99) < sr_pct);
  endtask

  // One clock cycle. It is entered and left at a falling edge.
  task automatic cycle();
    int           ch;
    bit           room, take, t0, t1;
    logic [W-1:0] d;
    drive_inputs();
    #1;
    room = (!m_op || Out_ready) && (!m_sp || S_ready);
    if (owner >= 0)                  ch = owner;
    else if (In0_valid && In1_valid) ch = pref;
    else if (In0_valid)              ch = 0;
    else if (In1_valid)              ch = 1;
    else                             ch = -1;
    check("out_valid", Out_valid, m_op);
    check("s_valid",   S_valid,   m_sp);
    check("out_data",  Out_data,  m_data);
    check("s_data",    S_data,    m_src);
    check("in0_ready", In0_ready, room && ch == 0);
    check("in1_ready", In1_ready, room && ch == 1);
    if (Out_valid && Out_ready) begin
      o_log.push_back(Out_data);
      if (exp_out.size() == 0) check("out_extra", 1, 0);
      else                     check("out_order", Out_data, exp_out.pop_front());
    end
    if (S_valid && S_ready) begin
      s_log.push_back(S_data);
      if (exp_s.size() == 0) check("s_extra", 1, 0);
      else                   check("s_order", S_data, exp_s.pop_front());
    end
    t0 = In0_valid && In0_ready;
    t1 = In1_valid && In1_ready;
    take = room && ch >= 0 && (ch == 0 ? In0_valid : In1_valid);
    d    = (ch == 1) ? In1_data : In0_data;
    @(posedge CLK);
    if (Out_ready) m_op = 0;
    if (S_ready)   m_sp = 0;
    if (take) begin
      m_op = 1; m_sp = 1; m_data = d; m_src = (ch == 1);
      exp_out.push_back(d);
      exp_s.push_back(ch == 1);
      if (d[TB]) begin
        owner = -1;
        pref  = 1 - ch;
      end else begin
        owner = ch;
      end
    end
    if (t0) void'(q0.pop_front());
    if (t1) void'(q1.pop_front());
    last_t0 = t0;
    last_t1 = t1;
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Called at a falling edge. It asserts reset mid-cycle and checks the
  // immediate effect, then releases reset two falling edges later.
  task automatic do_reset();
    RESET = 1'b1;
    In0_valid = 1'b0;
    In1_valid = 1'b0;
    #1;
    check("rst_out_valid", Out_valid, 0);
    check("rst_s_valid",   S_valid,   0);
    check("rst_out_data",  Out_data,  0);
    check("rst_s_data",    S_data,    0);
    check("rst_in0_ready", In0_ready, 0);
    check("rst_in1_ready", In1_ready, 0);
    owner = -1; pref = 0; m_op = 0; m_sp = 0; m_src = 0; m_data = '0;
    exp_out.delete(); exp_s.delete(); o_log.delete(); s_log.delete();
    q0.delete(); q1.delete();
    last_t0 = 0; last_t1 = 0;
    go0 = 100; go1 = 100; or_pct = 100; sr_pct = 100;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic gen_packets(input int src, input int nflits);
    int           cnt;
    int           len;
    logic [W-1:0] d;
    cnt = 0;
    while (cnt < nflits) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        d = 9'($urandom_range(0, 255));
        d[TB] = (k == len - 1);
        if (src == 0) q0.push_back(d);
        else          q1.push_back(d);
        cnt++;
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    In0_valid = 1'b0; In1_valid = 1'b0; In0_data = '0; In1_data = '0;
    Out_ready = 1'b0; S_ready = 1'b0;
    #1;
    check("init_out_valid", Out_valid, 0);
    check("init_s_valid",   S_valid,   0);
    check("init_in0_ready", In0_ready, 0);
    check("init_in1_ready", In1_ready, 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Single input, two flits, no bubbles.
    q0.push_back(9'h0A5);
    q0.push_back(9'h1FF);
    run(4);
    check("single_cnt", o_log.size(), 2);
    check("single_d0",  o_log[0], 9'h0A5);
    check("single_d1",  o_log[1], 9'h1FF);
    check("single_s0",  s_log[0], 0);
    check("single_s1",  s_log[1], 0);

    // Contention between single-flit packets alternates starting at In0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(9'h100);
      q1.push_back(9'h101);
    end
    run(10);
    check("cont_cnt", s_log.size(), 8);
    for (int i = 0; i < 4; i++) begin
      check("cont_s", s_log[i], i % 2);
      check("cont_d", o_log[i], (i % 2) ? 9'h101 : 9'h100);
    end

    // Packet lock: In1's 3-flit packet goes before In0's flit that arrives late.
    do_reset();
    q1.push_back(9'h011);
    q1.push_back(9'h022);
    q1.push_back(9'h133);
    q0.push_back(9'h144);
    go0 = 0;
    run(1);
    go0 = 100;
    run(6);
    check("lock_cnt", o_log.size(), 4);
    check("lock_d0", o_log[0], 9'h011);
    check("lock_d2", o_log[2], 9'h133);
    check("lock_d3", o_log[3], 9'h144);
    check("lock_s2", s_log[2], 1);
    check("lock_s3", s_log[3], 0);

    // Split backpressure: Out retires, S holds for 3 cycles.
    do_reset();
    q0.push_back(9'h1A1);
    q0.push_back(9'h1A2);
    q0.push_back(9'h1A3);
    run(1);
    sr_pct = 0;
    run(3);
    check("split_out_drop", Out_valid, 0);
    check("split_s_hold",   S_valid,   1);
    sr_pct = 100;
    run(6);
    check("split_cnt", o_log.size(), 3);
    check("split_scnt", s_log.size(), 3);
    check("split_d1", o_log[1], 9'h1A2);
    check("split_d2", o_log[2], 9'h1A3);

    // Reset in the middle of an In0 packet, then recovery from IDLE.
    do_reset();
    q0.push_back(9'h055);
    run(1);
    check("mid_loaded", Out_valid, 1);
    do_reset();
    q1.push_back(9'h166);
    run(3);
    check("recov_cnt", o_log.size(), 1);
    check("recov_d",   o_log[0], 9'h166);
    check("recov_s",   s_log[0], 1);

    // Randomised traffic with random backpressure, then a full drain.
    do_reset();
    gen_packets(0, 40);
    gen_packets(1, 40);
    for (int c = 0; c < 15; c++) begin
      go0    = $urandom_range(30, 100);
      go1    = $urandom_range(30, 100);
      or_pct = $urandom_range(40, 100);
      sr_pct = $urandom_range(40, 100);
      run(20);
    end
    go0 = 100; go1 = 100; or_pct = 100; sr_pct = 100;
    run(120);
    check("drain_out", exp_out.size(), 0);
    check("drain_s",   exp_s.size(),   0);
    check("drain_q0",  q0.size(),      0);
    check("drain_q1",  q1.size(),      0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
